// File: rtl/load_store_unit.sv
// Memory stage after the ALU: issues one req/ack data access per start,
// formats byte/half/word data and holds busy until the done pulse.
//
// Ports: clk, rst_n (async, active-low); start/is_store/funct3/addr/wdata
// from execute; busy/done/rdata/fault to the pipeline; mem_* to data memory.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_store;
  logic [2:0]    r_f3;
  logic [1:0]    r_off;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [31:0]   r_maddr;
  logic [3:0]    r_be;
  logic [31:0]   r_wd;
  logic [31:0]   r_rdata;
  logic [1:0]    r_fault;

  logic          w_legal;
  logic          w_misal;
  logic          w_ok;
  logic          w_tmo;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_sh;
  logic [31:0]   w_ld;

  // Request-side decode straight from the execute inputs.
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~is_store;
      default:                w_legal = 1'b0;
    endcase
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wd    = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_be = 4'b0001 << addr[1:0];
        w_wd = {4{wdata[7:0]}};
      end
      2'b01: begin
        w_misal = addr[0];
        w_be    = 4'b0011 << {addr[1], 1'b0};
        w_wd    = {2{wdata[15:0]}};
      end
      default: begin
        w_misal = |addr[1:0];
      end
    endcase
  end

  assign w_ok  = w_legal & ~w_misal;
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  // Lane select: aligned halves have r_off[0]=0, so a byte shift covers both.
  always_comb begin
    w_sh = mem_rdata >> {r_off, 3'b000};
    case (r_f3)
      3'b000:  w_ld = {{24{w_sh[7]}}, w_sh[7:0]};
      3'b001:  w_ld = {{16{w_sh[15]}}, w_sh[15:0]};
      3'b100:  w_ld = {24'h0, w_sh[7:0]};
      3'b101:  w_ld = {16'h0, w_sh[15:0]};
      default: w_ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = w_ok ? S_REQ : S_DONE;
      S_REQ:  if (mem_ack || w_tmo) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store <= 1'b0;
      r_f3    <= 3'b0;
      r_off   <= 2'b0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_maddr <= 32'h0;
      r_be    <= 4'h0;
      r_wd    <= 32'h0;
      r_rdata <= 32'h0;
      r_fault <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_store <= is_store;
            r_f3    <= funct3;
            r_off   <= addr[1:0];
            r_cnt   <= '0;
            // Memory port only moves for accesses that will be issued.
            if (w_ok) begin
              r_we    <= is_store;
              r_maddr <= {addr[31:2], 2'b00};
              r_be    <= w_be;
              r_wd    <= w_wd;
            end else begin
              r_rdata <= 32'h0;
              r_fault <= w_legal ? 2'b01 : 2'b10;
            end
          end
        end
        S_REQ: begin
          if (r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
          if (mem_ack) begin
            r_rdata <= r_store ? 32'h0 : w_ld;
            r_fault <= 2'b00;
          end else if (w_tmo) begin
            r_rdata <= 32'h0;
            r_fault <= 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_req   = (r_state == S_REQ);
  assign mem_we    = r_we;
  assign mem_addr  = r_maddr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wd;
  assign rdata     = r_rdata;
  assign fault     = r_fault;

endmodule
